// File: rtl/sdpb_reader_pkg.sv
// Shared definitions for the SDPB stream reader: FSM state encoding and the
// RAM read-path latency (ceb to FIFO push).
package sdpb_reader_pkg;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      ISSUE  = 2'd1,
      DRAIN  = 2'd2,
      FINISH = 2'd3
   } state_t;

   localparam int RD_LATENCY = 2;

endpackage

// File: rtl/sdpb_reader_fifo.sv
// Output skid FIFO for the SDPB stream reader. It accepts a push into a full
// FIFO when a pop happens in the same cycle.
module sdpb_reader_fifo #(
   parameter int DEPTH = 4,
   parameter int WIDTH = 16
) (
   input  logic                       clk,
   input  logic                       resetn,
   input  logic                       push,
   input  logic                       pop,
   input  logic [WIDTH-1:0]           din,
   output logic [WIDTH-1:0]           dout,
   output logic                       empty,
   output logic                       full,
   output logic [$clog2(DEPTH+1)-1:0] count
);

   localparam int PW = $clog2(DEPTH);
   localparam int CW = $clog2(DEPTH+1);

   logic [WIDTH-1:0] r_mem [DEPTH];
   logic [PW-1:0]    r_wr_ptr;
   logic [PW-1:0]    r_rd_ptr;
   logic [CW-1:0]    r_count;
   logic             w_push;
   logic             w_pop;

   function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
      return (p == PW'(DEPTH-1)) ? '0 : p + PW'(1);
   endfunction

   assign empty  = (r_count == '0);
   assign full   = (r_count == CW'(DEPTH));
   assign count  = r_count;
   // Head reads as zero when empty so stale storage never leaks out.
   assign dout   = empty ? '0 : r_mem[r_rd_ptr];
   assign w_pop  = pop & ~empty;
   assign w_push = push & (~full | w_pop);

   always_ff @(posedge clk) begin
      if (w_push) r_mem[r_wr_ptr] <= din;
   end

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_count  <= '0;
      end else begin
         if (w_push) r_wr_ptr <= ptr_inc(r_wr_ptr);
         if (w_pop)  r_rd_ptr <= ptr_inc(r_rd_ptr);
         if (w_push && !w_pop)      r_count <= r_count + CW'(1);
         else if (w_pop && !w_push) r_count <= r_count - CW'(1);
      end
   end

endmodule

// File: rtl/sdpb_stream_reader.sv
// Burst reader for one port of a semi-dual-port block RAM, streaming words out
// through a skid FIFO. Define SDPB_READER_DOUBLE_BUFFER_EN for two-bank swapping.
module sdpb_stream_reader
   import sdpb_reader_pkg::*;
#(
   parameter int ADDRESS_DEPTH_B = 1024,
   parameter int DATA_WIDTH_B    = 16,
   parameter int FIFO_DEPTH      = 4
) (
   input  logic                               clk,
   input  logic                               resetn,
   input  logic                               start,
   input  logic [$clog2(ADDRESS_DEPTH_B)-1:0] base_addr,
   input  logic [$clog2(ADDRESS_DEPTH_B):0]   length,
   input  logic                               swap_req,
   output logic [$clog2(ADDRESS_DEPTH_B)-1:0] adb,
   output logic                               ceb,
   output logic                               oce,
   input  logic [DATA_WIDTH_B-1:0]            rd_data,
   output logic [DATA_WIDTH_B-1:0]            m_data,
   output logic                               m_valid,
   input  logic                               m_ready,
   output logic                               busy,
   output logic                               done,
   output logic                               bank
);

   localparam int AW = $clog2(ADDRESS_DEPTH_B);
   localparam int CW = $clog2(FIFO_DEPTH+1);
   localparam int LW = $clog2(RD_LATENCY+1);
   localparam int OW = CW + LW;

   state_t        r_state;
   state_t        w_next;
   logic [AW-1:0] r_addr;
   logic [AW:0]   r_remain;
   logic          r_oce;
   logic          r_push;
   logic          r_zero_done;
   logic [LW-1:0] r_inflight;
   logic [CW-1:0] w_count;
   logic [OW-1:0] w_occ;
   logic [AW-1:0] w_adb;
   logic          w_empty;
   logic          w_full;
   logic          w_go;
   logic          w_issue;
   logic          w_pop;
   logic          w_unused;

   assign w_go    = (r_state == IDLE) & start & (length != '0);
   // Words already buffered plus words still in the RAM pipe must leave room.
   assign w_occ   = OW'(w_count) + OW'(r_inflight);
   assign w_issue = (r_state == ISSUE) & (w_occ < OW'(FIFO_DEPTH));
   assign w_pop   = m_valid & m_ready;

   always_comb begin
      w_next = r_state;
      case (r_state)
         IDLE:    if (w_go) w_next = ISSUE;
         ISSUE:   if (w_issue && r_remain == (AW+1)'(1)) w_next = DRAIN;
         DRAIN:   if (r_inflight == '0 && w_empty) w_next = FINISH;
         FINISH:  w_next = IDLE;
         default: w_next = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         r_state     <= IDLE;
         r_addr      <= '0;
         r_remain    <= '0;
         r_oce       <= 1'b0;
         r_push      <= 1'b0;
         r_inflight  <= '0;
         r_zero_done <= 1'b0;
      end else begin
         r_state     <= w_next;
         r_oce       <= w_issue;
         r_push      <= r_oce;
         r_zero_done <= (r_state == IDLE) & start & (length == '0);
         if (w_issue && !r_push)      r_inflight <= r_inflight + LW'(1);
         else if (!w_issue && r_push) r_inflight <= r_inflight - LW'(1);
         if (w_go) begin
            r_addr   <= base_addr;
            r_remain <= length;
         end else if (w_issue) begin
            r_addr   <= r_addr + AW'(1);
            r_remain <= r_remain - (AW+1)'(1);
         end
      end
   end

`ifdef SDPB_READER_DOUBLE_BUFFER_EN
   logic r_bank;
   logic r_swap_pend;

   // A swap only takes effect when a new burst launches.
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         r_bank      <= 1'b0;
         r_swap_pend <= 1'b0;
      end else if (w_go) begin
         if (r_swap_pend) r_bank <= ~r_bank;
         r_swap_pend <= swap_req;
      end else if (swap_req) begin
         r_swap_pend <= 1'b1;
      end
   end

   assign bank     = r_bank;
   assign w_adb    = {r_bank, r_addr[AW-2:0]};
   assign w_unused = r_addr[AW-1];
`else
   assign bank     = 1'b0;
   assign w_adb    = r_addr;
   assign w_unused = swap_req;
`endif

   assign adb  = w_issue ? w_adb : '0;
   assign ceb  = w_issue;
   assign oce  = r_oce;
   assign busy = (r_state != IDLE);
   assign done = (r_state == FINISH) | r_zero_done;

   sdpb_reader_fifo #(
      .DEPTH (FIFO_DEPTH),
      .WIDTH (DATA_WIDTH_B)
   ) u_fifo (
      .clk    (clk),
      .resetn (resetn),
      .push   (r_push),
      .pop    (w_pop),
      .din    (rd_data),
      .dout   (m_data),
      .empty  (w_empty),
      .full   (w_full),
      .count  (w_count)
   );

   assign m_valid = ~w_empty;

endmodule

// File: tb/tb_sdpb_stream_reader.sv
// Scoreboard bench for sdpb_stream_reader; RAM model returns each word's own
// address. Bank expectations follow SDPB_READER_DOUBLE_BUFFER_EN.
module tb_sdpb_stream_reader;

   localparam int MAX_CYC = 400;

   logic        clk;
   logic        resetn;
   logic        start;
   logic [9:0]  base_addr;
   logic [10:0] length;
   logic        swap_req;
   logic [9:0]  adb;
   logic        ceb;
   logic        oce;
   logic [15:0] rd_data;
   logic [15:0] m_data;
   logic        m_valid;
   logic        m_ready;
   logic        busy;
   logic        done;
   logic        bank;

   logic [15:0] r_ram_q;
   logic [9:0]  exp_addr[$];
   logic [15:0] exp_data[$];
   logic        cur_bank;
   int          n_checks;
   int          n_fail;
   int          done_cnt;
   int          outst;

   sdpb_stream_reader dut (
      .clk       (clk),
      .resetn    (resetn),
      .start     (start),
      .base_addr (base_addr),
      .length    (length),
      .swap_req  (swap_req),
      .adb       (adb),
      .ceb       (ceb),
      .oce       (oce),
      .rd_data   (rd_data),
      .m_data    (m_data),
      .m_valid   (m_valid),
      .m_ready   (m_ready),
      .busy      (busy),
      .done      (done),
      .bank      (bank)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Two-stage RAM: array read on ceb, output register loaded on oce.
   always @(posedge clk) begin
      if (ceb) r_ram_q <= 16'(adb);
      if (oce) rd_data <= r_ram_q;
   end

   task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
      end
   endtask

   function automatic logic ready_for(input int mode, input int c);
      case (mode)
         0:       return 1'b1;
         1:       return (c % 2) == 0;
         default: return 1'($urandom_range(0, 1));
      endcase
   endfunction

   task automatic push_expect(input logic [9:0] base, input int len);
      logic [9:0] a;
      logic [8:0] lo;
      for (int i = 0; i < len; i++) begin
`ifdef SDPB_READER_DOUBLE_BUFFER_EN
         lo = base[8:0] + 9'(i);
         a  = {cur_bank, lo};
`else
         lo = '0;
         a  = base + 10'(i);
`endif
         exp_addr.push_back(a);
         exp_data.push_back(16'(a));
      end
   endtask

   // Called once per cycle, 1 time unit after the rising edge.
   task automatic sample_cycle();
      if (ceb) begin
         outst++;
         if (exp_addr.size() == 0) check_eq("ceb_unexpected", 32'(ceb), 32'd0);
         else begin
            check_eq("adb", 32'(adb), 32'(exp_addr.pop_front()));
            check_eq("bank", 32'(bank), 32'(cur_bank));
         end
         check_eq("outstanding_le_depth", 32'(outst <= 4), 32'd1);
      end
      if (m_valid && m_ready) begin
         outst--;
         if (exp_data.size() == 0) check_eq("data_unexpected", 32'(m_valid), 32'd0);
         else check_eq("m_data", 32'(m_data), 32'(exp_data.pop_front()));
      end
      if (done) done_cnt++;
   endtask

   task automatic check_outputs_zero(input string tag);
      check_eq({tag, "_adb"},     32'(adb),     32'd0);
      check_eq({tag, "_ceb"},     32'(ceb),     32'd0);
      check_eq({tag, "_oce"},     32'(oce),     32'd0);
      check_eq({tag, "_m_valid"}, 32'(m_valid), 32'd0);
      check_eq({tag, "_busy"},    32'(busy),    32'd0);
      check_eq({tag, "_done"},    32'(done),    32'd0);
      check_eq({tag, "_bank"},    32'(bank),    32'd0);
   endtask

   // Cycle 0 is the cycle in which start is high.
   task automatic run_burst(input string name, input logic [9:0] base, input int len,
                            input int mode, input bit inject);
      int d0;
      int first_vld;
      int done_c;
      bit busy_seen;
      bit fin;
      push_expect(base, len);
      d0        = done_cnt;
      first_vld = -1;
      done_c    = -1;
      busy_seen = 1'b0;
      fin       = 1'b0;
      base_addr = base;
      length    = 11'(len);
      start     = 1'b1;
      m_ready   = ready_for(mode, 0);
      sample_cycle();
      @(posedge clk); #1;
      start = 1'b0;
      for (int c = 1; c < MAX_CYC && !fin; c++) begin
         m_ready = ready_for(mode, c);
         if (inject && c == 3) begin
            start     = 1'b1;
            swap_req  = 1'b1;
            base_addr = 10'h077;
            length    = 11'd5;
         end else begin
            start    = 1'b0;
            swap_req = 1'b0;
         end
         sample_cycle();
         if (m_valid && first_vld < 0) first_vld = c;
         if (done && done_c < 0) done_c = c;
         if (busy) busy_seen = 1'b1;
         fin = (done_cnt != d0) && !busy;
         @(posedge clk); #1;
      end
      start    = 1'b0;
      swap_req = 1'b0;
      repeat (2) begin
         sample_cycle();
         @(posedge clk); #1;
      end
      check_eq({name, "_finished"},   32'(fin), 32'd1);
      check_eq({name, "_done_count"}, 32'(done_cnt - d0), 32'd1);
      check_eq({name, "_words_left"}, 32'(exp_data.size()), 32'd0);
      check_eq({name, "_addrs_left"}, 32'(exp_addr.size()), 32'd0);
      check_eq({name, "_outstanding"}, 32'(outst), 32'd0);
      if (len > 0) begin
         check_eq({name, "_first_valid_cycle"}, 32'(first_vld), 32'd4);
      end else begin
         check_eq({name, "_done_cycle"}, 32'(done_c), 32'd1);
         check_eq({name, "_busy_seen"},  32'(busy_seen), 32'd0);
      end
   endtask

   initial begin
      int d0;
      n_checks  = 0;
      n_fail    = 0;
      done_cnt  = 0;
      outst     = 0;
      cur_bank  = 1'b0;
      resetn    = 1'b1;
      start     = 1'b0;
      swap_req  = 1'b0;
      m_ready   = 1'b0;
      base_addr = '0;
      length    = '0;
      #2 resetn = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      check_outputs_zero("reset");
      resetn = 1'b1;
      @(posedge clk); #1;

      run_burst("basic",  10'h010, 8,  0, 1'b0);
      run_burst("toggle", 10'h020, 16, 1, 1'b0);
      run_burst("random", 10'h100, 20, 2, 1'b0);
`ifdef SDPB_READER_DOUBLE_BUFFER_EN
      run_burst("wrap",   10'h1FE, 4,  0, 1'b0);
`else
      run_burst("wrap",   10'h3FE, 4,  0, 1'b0);
`endif
      run_burst("zero_len", 10'h005, 0, 0, 1'b0);

      // Reset two cycles into an 8-word burst.
      push_expect(10'h040, 8);
      d0        = done_cnt;
      base_addr = 10'h040;
      length    = 11'd8;
      m_ready   = 1'b1;
      start     = 1'b1;
      sample_cycle();
      @(posedge clk); #1;
      start = 1'b0;
      repeat (2) begin
         sample_cycle();
         @(posedge clk); #1;
      end
      resetn = 1'b0;
      #1;
      check_outputs_zero("midreset");
      exp_addr.delete();
      exp_data.delete();
      outst = 0;
      repeat (2) @(posedge clk);
      #1;
      resetn = 1'b1;
      repeat (3) begin
         sample_cycle();
         @(posedge clk); #1;
      end
      check_eq("midreset_no_done", 32'(done_cnt - d0), 32'd0);
      run_burst("after_reset", 10'h050, 2, 0, 1'b0);

      // Swap requested mid-burst applies only at the following start.
      run_burst("swap_a", 10'h060, 6, 0, 1'b1);
`ifdef SDPB_READER_DOUBLE_BUFFER_EN
      cur_bank = 1'b1;
`endif
      run_burst("swap_b", 10'h030, 3, 0, 1'b0);
      check_eq("bank_after_swap", 32'(bank), 32'(cur_bank));

      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

endmodule
